// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/ack, decoded-instruction valid/ready,
// redirect and occupancy. "master" is the fetch queue, "slave" is its environment.
interface ifetch_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, count,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, count,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues imem reads, and queues tagged words.
// Optional IFQ_BYPASS_EN forwards an ack straight to instr_* when the queue is empty.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.master ifq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } entry_t;

  state_t        r_state, w_state_n;
  logic [31:0]   r_fetch_pc, w_fetch_pc_n;
  logic [31:0]   r_addr, w_addr_n;
  logic          r_req, w_req_n;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd_idx, r_wr_idx;
  logic [CW-1:0] r_count, w_count_n;
  logic [31:0]   w_redir_pc;
  logic          w_ack, w_push, w_pop, w_bypass, w_bypass_take;

  assign w_ack      = r_req & ifq.imem_ack;
  assign w_redir_pc = {ifq.redirect_pc[31:2], 2'b00};

`ifdef IFQ_BYPASS_EN
  // Empty queue and a live ack: present the returning word in the same cycle.
  assign w_bypass        = (r_state == REQ) && w_ack && !ifq.redirect && (r_count == '0);
  assign ifq.instr_valid = (r_count != '0) || w_bypass;
  assign ifq.instr       = w_bypass ? ifq.imem_rdata : r_mem[r_rd_idx].insn;
  assign ifq.instr_pc    = w_bypass ? r_fetch_pc     : r_mem[r_rd_idx].pc;
`else
  assign w_bypass        = 1'b0;
  assign ifq.instr_valid = (r_count != '0);
  assign ifq.instr       = r_mem[r_rd_idx].insn;
  assign ifq.instr_pc    = r_mem[r_rd_idx].pc;
`endif

  assign w_bypass_take = w_bypass & ifq.instr_ready;
  assign ifq.imem_req  = r_req;
  assign ifq.imem_addr = r_addr;
  assign ifq.count     = r_count;

  // Next-state, fetch PC and queue bookkeeping; redirect overrides everything.
  always_comb begin
    w_state_n    = r_state;
    w_fetch_pc_n = r_fetch_pc;
    w_push       = (r_state == REQ) && w_ack && !ifq.redirect && !w_bypass_take;
    w_pop        = (r_count != '0) && ifq.instr_ready && !ifq.redirect;
    if (ifq.redirect) w_count_n = '0;
    else              w_count_n = r_count + CW'(w_push) - CW'(w_pop);

    case (r_state)
      IDLE: begin
        if (ifq.redirect) begin
          w_state_n    = REQ;
          w_fetch_pc_n = w_redir_pc;
        end else if (r_count < CW'(DEPTH)) begin
          w_state_n = REQ;
        end
      end
      REQ: begin
        if (ifq.redirect) begin
          w_fetch_pc_n = w_redir_pc;
          w_state_n    = w_ack ? REQ : DROP;
        end else if (w_ack) begin
          w_fetch_pc_n = r_fetch_pc + 32'd4;
          w_state_n    = (w_count_n == CW'(DEPTH)) ? IDLE : REQ;
        end
      end
      DROP: begin
        if (ifq.redirect) w_fetch_pc_n = w_redir_pc;
        if (w_ack)        w_state_n    = REQ;
      end
      default: w_state_n = IDLE;
    endcase

    // An abandoned request keeps its address on the bus until the memory acks it.
    w_addr_n = (w_state_n == DROP) ? r_addr : w_fetch_pc_n;
    w_req_n  = (w_state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_count    <= '0;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_n;
      r_fetch_pc <= w_fetch_pc_n;
      r_addr     <= w_addr_n;
      r_req      <= w_req_n;
      r_count    <= w_count_n;
      if (ifq.redirect) begin
        r_rd_idx <= '0;
        r_wr_idx <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_idx] <= '{insn: ifq.imem_rdata, pc: r_fetch_pc};
          r_wr_idx        <= r_wr_idx + AW'(1);
        end
        if (w_pop) r_rd_idx <= r_rd_idx + AW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(DEPTH))));

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, each tagged with its PC, in a small prefetch FIFO.
- Presents the FIFO head to the decode/execute stage over valid/ready; a branch/jump redirect flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of 2, >= 2)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word address of request (bits [1:0] always 0)
- imem_ack  input  1  memory accepts request and returns data this cycle
- imem_rdata  input  32  instruction word, valid when imem_req & imem_ack
- instr_valid  output  1  FIFO head valid
- instr  output  32  FIFO head instruction
- instr_pc  output  32  PC of FIFO head
- instr_ready  input  1  consumer takes head this cycle
- redirect  input  1  flush queue, restart fetch at redirect_pc
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0)
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, count=0, fetch_pc=RESET_PC, state=IDLE.
- FSM states:
  - IDLE: imem_req=0. Goes to REQ when count < DEPTH and no redirect.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until ack. On ack: push {imem_rdata, fetch_pc} and set fetch_pc += 4 (wraps modulo 2^32). After the push, stay in REQ if post-update count < DEPTH, else go to IDLE.
  - DROP: imem_req=1, imem_addr=stale address held stable. On ack the data is discarded and the FSM goes to REQ.
- First imem_req=1 appears in the first rising edge after rst_n deasserts; IDLE lasts 1 cycle.
- At most one outstanding request; req only issued with a free slot, so no overflow is possible. Push into a full FIFO is a design error, covered by an assertion.
- Pop: when instr_valid & instr_ready, the head is removed on that edge. instr_valid = (count != 0).
- Latency: ack in cycle N -> instr_valid=1 in cycle N+1 (default build).
- Simultaneous push and pop: count unchanged; FIFO order preserved.
- Redirect (registered effect on the next edge; highest priority):
  - FIFO emptied: count=0, instr_valid=0 next cycle. A same-cycle pop is void and the consumer must not commit it.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - In IDLE, or in REQ with same-cycle ack (ack data dropped): go to REQ with the new address.
  - In REQ without ack: go to DROP, keeping the old address until ack.
  - In DROP: stay in DROP, fetch_pc updated to the latest redirect_pc.
- Back-to-back redirects: the last one wins.
- Reset mid-transaction: immediate return to reset values. The memory must tolerate abandonment of the pending request.
- Pointers: read/write indices of width $clog2(DEPTH) wrap naturally; count distinguishes full from empty.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0 and the ack is not dropped, instr_valid, instr and instr_pc are driven combinationally from imem_rdata and fetch_pc in the ack cycle (0-cycle latency).
  - If instr_ready is also 1, the word is consumed and not written to the FIFO.
  - Otherwise it is written to the FIFO normally.
- Undefined: no combinational path from imem_* to instr_*; latency is 1 cycle.

Test Plan:
- Reset release, imem_ack tied 1, instr_ready tied 1: imem_addr = 0,4,8,... each cycle; instr/instr_pc follow 1 cycle later (0 cycles with IFQ_BYPASS_EN); count stays <= 1.
- instr_ready=0, ack=1, DEPTH=4: 4 pushes (PCs 0x0,0x4,0x8,0xC), count=4, imem_req=0. Raise ready for 1 cycle: exactly one refetch, at 0x10.
- Redirect to 0x0000_0100 while in REQ with ack held 0 for 3 cycles: FSM enters DROP, imem_addr stays at old address until ack, data discarded. Next req at 0x100; first instr_pc out = 0x100; count=0 on the cycle after redirect.
- Redirect with same-cycle ack and pop: acked word and popped head are both absent afterwards; next instr_pc = redirect target; redirect_pc=0x203 yields fetch at 0x200.
- Wrap: redirect_pc=0xFFFF_FFFC, ack=1: fetches 0xFFFF_FFFC then 0x0000_0000; instr_pc sequence matches.
- Assert rst_n=0 mid-DROP with count=3: outputs at reset values immediately; after release, first imem_addr=RESET_PC.
